// File: rtl/mac_accumulator.sv
// Frame multiply-accumulate: sums 13-bit products into an ACC_W accumulator and presents one result per frame.
// Optional MAC_SATURATE_EN clamps the sum on overflow; the default build wraps modulo 2^ACC_W.
module mac_accumulator #(
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic [12:0]      prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [6:0]       out_count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_TERMS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [6:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;

  logic             mode_eff;
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum;
  logic             s_ovf;
  logic             u_ovf;
  logic             add_ovf;
  logic [ACC_W-1:0] add_val;
  logic [6:0]       count_inc;

  // The first term of a frame takes its mode straight from t; later terms use the latched mode.
  assign mode_eff  = (state_q == S_IDLE) ? t : mode_q;
  assign ext       = {{(ACC_W-13){mode_eff & prod[12]}}, prod};
  assign sum_wide  = {1'b0, acc_q} + {1'b0, ext};
  assign sum       = sum_wide[ACC_W-1:0];
  assign s_ovf     = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign u_ovf     = sum_wide[ACC_W];
  assign add_ovf   = mode_q ? s_ovf : u_ovf;
  assign count_inc = count_q + 7'd1;

`ifdef MAC_SATURATE_EN
  // Signed overflow can only happen when both operands share a sign, so ext's sign picks the rail.
  assign add_val = !add_ovf ? sum :
                   !mode_q  ? {ACC_W{1'b1}} :
                   ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign add_val = sum;
`endif

  // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mode_d  = t;
          acc_d   = ext;
          count_d = 7'd1;
          ovf_d   = 1'b0;
          state_d = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d   = add_val;
          count_d = count_inc;
          ovf_d   = ovf_q | add_ovf;
          if (in_last || (count_inc == MAX_CNT)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign acc_out   = acc_q;
  assign out_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: an arithmetic frame model predicts each result,
// a negedge monitor compares on every output handshake.
module tb_mac_accumulator;

  localparam int ACC_W     = 16;
  localparam int MAX_TERMS = 64;
  localparam longint SMAX  = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint SMIN  = -(64'sd1 <<< (ACC_W-1));
  localparam longint UMAX  = (64'sd1 <<< ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             t;
  logic [12:0]      prod;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [6:0]       out_count;
  logic             overflow;

  logic rand_en   = 1'b0;
  logic rnd_ready = 1'b0;
  logic dir_ready = 1'b0;
  assign out_ready = rand_en ? rnd_ready : dir_ready;

  mac_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk       (clk),
    .rst       (rst),
    .t         (t),
    .prod      (prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .out_count (out_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] acc;
    int               cnt;
    bit               ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Frame model state: the running mathematical sum (clamped when saturating).
  bit     m_open = 0;
  bit     m_mode = 0;
  longint m_v    = 0;
  int     m_n    = 0;
  bit     m_ovf  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint ext_of(input bit mode, input logic [12:0] p);
    if (mode && p[12]) return longint'(p) - 8192;
    return longint'(p);
  endfunction

  task automatic model_xfer(input bit tt, input logic [12:0] p, input bit last);
    exp_t e;
    if (!m_open) begin
      m_open = 1;
      m_mode = tt;
      m_v    = ext_of(tt, p);
      m_n    = 1;
      m_ovf  = 0;
    end else begin
      m_v = m_v + ext_of(m_mode, p);
      m_n++;
      if (m_mode) begin
        if (m_v > SMAX || m_v < SMIN) begin
          m_ovf = 1;
`ifdef MAC_SATURATE_EN
          m_v = (m_v > SMAX) ? SMAX : SMIN;
`endif
        end
      end else if (m_v > UMAX) begin
        m_ovf = 1;
`ifdef MAC_SATURATE_EN
        m_v = UMAX;
`endif
      end
    end
    if (last || m_n == MAX_TERMS) begin
      e.acc  = ACC_W'(m_v);
      e.cnt  = m_n;
      e.ovf  = m_ovf;
      sb_q.push_back(e);
      m_open = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the edge that took the term.
  task automatic send(input bit tt, input logic [12:0] p, input bit last);
    t = tt; prod = p; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_xfer(tt, p, last);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_hold(input string name, input longint a, input longint c, input longint o);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_acc"},   acc_out,   a);
    check({name, "_cnt"},   out_count, c);
    check({name, "_ovf"},   overflow,  o);
  endtask

  task automatic release_hold();
    dir_ready = 1'b1;
    @(posedge clk); #1;
    dir_ready = 1'b0;
    check("release_idle", out_valid, 0);
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("mon_acc", acc_out,   mon_e.acc);
        check("mon_cnt", out_count, mon_e.cnt);
        check("mon_ovf", overflow,  mon_e.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [12:0] p;
    rst = 1'b1; t = 0; prod = '0; in_valid = 0; in_last = 0;
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc",       acc_out,   0);
    check("rst_cnt",       out_count, 0);
    check("rst_ovf",       overflow,  0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Unsigned 3 x 0x1FFF with one cycle latency to HOLD.
    send(0, 13'h1FFF, 0);
    send(0, 13'h1FFF, 0);
    send(0, 13'h1FFF, 1);
    expect_hold("u3", 16'h5FFD, 3, 0);
    release_hold();

    // Signed 2 x -4096.
    send(1, 13'h1000, 0);
    send(0, 13'h1000, 1);
    expect_hold("s2", 16'hE000, 2, 0);
    release_hold();

    // Unsigned overflow over nine terms.
    for (int i = 0; i < 9; i++) send(0, 13'h1FFF, i == 8);
`ifdef MAC_SATURATE_EN
    expect_hold("u9", 16'hFFFF, 9, 1);
`else
    expect_hold("u9", 16'h1FF7, 9, 1);
`endif
    release_hold();

    // Auto-close at MAX_TERMS with in_last held low.
    for (int i = 0; i < 64; i++) send(0, 13'h0001, 0);
    expect_hold("max", 64, 64, 0);
    release_hold();

    // Back-pressure: pending input must not be consumed while HOLD is stalled.
    send(0, 13'd3, 0);
    send(0, 13'd4, 1);
    t = 0; prod = 13'd9; in_last = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready,  0);
      check("bp_acc",      acc_out,   7);
      check("bp_cnt",      out_count, 2);
      @(posedge clk); #1;
    end
    dir_ready = 1'b1;
    @(posedge clk); #1;
    dir_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    send(0, 13'd9, 1);
    expect_hold("bp_next", 9, 1, 0);
    release_hold();

    // Reset mid-frame discards the partial sum.
    send(0, 13'd100, 0);
    send(0, 13'd100, 0);
    send(0, 13'd100, 0);
    rst = 1'b1;
    #1;
    m_open = 0;
    check("mid_rst_in_ready",  in_ready,  1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_acc",       acc_out,   0);
    check("mid_rst_cnt",       out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 13'd5, 1);
    expect_hold("after_rst", 5, 1, 0);
    release_hold();

    // Randomized frames with random back-pressure.
    rand_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       p = 13'h1FFF;
          1:       p = 13'h1000;
          default: p = 13'($urandom);
        endcase
        send(1'($urandom_range(0, 1)), p, k == n - 1);
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
    for (int i = 0; i < 1000 && (sb_q.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    rand_en = 1'b0;
    check("drain_empty", sb_q.size(), 0);
    check("drain_idle",  out_valid,   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
